// File: rtl/key_pkg.sv
// Shared types and helpers for the key_pulse_gen debouncer slice.
// Autorepeat is enabled by defining KEY_PULSE_AUTOREPEAT_EN.
package key_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_WAIT,
        S_PRESSED,
        S_REL_WAIT
    } key_state_e;

    // Raw keys are active-low: a 0 on the pin means pressed.
    localparam logic KEY_ACTIVE = 1'b0;

    // Counter must hold the largest compare value of debounce and repeat timing.
    function automatic int cnt_width(input int deb, input int rep_delay, input int rep_period);
        int m;
        m = deb;
        if (rep_delay > m) m = rep_delay;
        if (rep_period > m) m = rep_period;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchroniser, debounce FSM, registered pulse/level.
// Optional autorepeat counter when KEY_PULSE_AUTOREPEAT_EN is defined.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEB_CYCLES = 20,
    parameter int REP_DELAY  = 5000,
    parameter int REP_PERIOD = 1000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key,
    output logic o_pulse,
    output logic o_level
);

    localparam int CW = cnt_width(DEB_CYCLES, REP_DELAY, REP_PERIOD);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic          pressed_s;
    key_state_e    state;
    key_state_e    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          pulse_q;
    logic          pulse_nxt;
    logic          level_q;
    logic          level_nxt;
    logic          rep_fire;

    // Synchroniser resets to the released level so reset never looks like a press.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= i_key;
            sync_p1 <= sync_p0;
        end
    end

    assign pressed_s = (sync_p1 == KEY_ACTIVE);

`ifdef KEY_PULSE_AUTOREPEAT_EN
    localparam logic [CW-1:0] REP_FIRST_LAST = CW'(REP_DELAY - 1);
    localparam logic [CW-1:0] REP_NEXT_LAST  = CW'(REP_PERIOD - 1);

    logic [CW-1:0] rep_cnt;
    logic [CW-1:0] rep_cnt_nxt;
    logic          rep_armed;
    logic          rep_armed_nxt;

    // Counts only while the key is steadily held; frozen during release debounce.
    always_comb begin
        rep_cnt_nxt   = rep_cnt;
        rep_armed_nxt = rep_armed;
        rep_fire      = 1'b0;
        if (state == S_PRESSED && pressed_s) begin
            if (rep_cnt == (rep_armed ? REP_NEXT_LAST : REP_FIRST_LAST)) begin
                rep_fire      = 1'b1;
                rep_cnt_nxt   = '0;
                rep_armed_nxt = 1'b1;
            end else begin
                rep_cnt_nxt = rep_cnt + 1'b1;
            end
        end else if (state == S_IDLE) begin
            rep_cnt_nxt   = '0;
            rep_armed_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
        end else begin
            rep_cnt   <= rep_cnt_nxt;
            rep_armed <= rep_armed_nxt;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pulse_nxt = 1'b0;
        level_nxt = level_q;
        case (state)
            S_IDLE: begin
                if (pressed_s) begin
                    state_nxt = S_PRESS_WAIT;
                    cnt_nxt   = CW'(1);
                end else begin
                    cnt_nxt = '0;
                end
            end
            S_PRESS_WAIT: begin
                if (!pressed_s) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = S_PRESSED;
                    cnt_nxt   = '0;
                    pulse_nxt = 1'b1;
                    level_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_PRESSED: begin
                if (!pressed_s) begin
                    state_nxt = S_REL_WAIT;
                    cnt_nxt   = CW'(1);
                end else begin
                    cnt_nxt   = '0;
                    pulse_nxt = rep_fire;
                end
            end
            S_REL_WAIT: begin
                // A bounce back to pressed restores the held state without a new pulse.
                if (pressed_s) begin
                    state_nxt = S_PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                    level_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
                level_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pulse_q <= pulse_nxt;
            level_q <= level_nxt;
        end
    end

    assign o_pulse = pulse_q;
    assign o_level = level_q;

endmodule

// File: rtl/key_pulse_gen.sv
// Debounced key front end: NUM_KEYS independent channels of clean press pulses.
// Define KEY_PULSE_AUTOREPEAT_EN to add hold-to-repeat pulses.
module key_pulse_gen
    import key_pkg::*;
#(
    parameter int NUM_KEYS   = 3,
    parameter int DEB_CYCLES = 20,
    parameter int REP_DELAY  = 5000,
    parameter int REP_PERIOD = 1000
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NUM_KEYS-1:0] i_key,
    output logic [NUM_KEYS-1:0] o_pulse,
    output logic [NUM_KEYS-1:0] o_level
);

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .DEB_CYCLES (DEB_CYCLES),
            .REP_DELAY  (REP_DELAY),
            .REP_PERIOD (REP_PERIOD)
        ) u_ch (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_key   (i_key[g]),
            .o_pulse (o_pulse[g]),
            .o_level (o_level[g])
        );
    end

endmodule

// File: tb/tb_key_pulse_gen.sv
// Bench for key_pulse_gen: directed scenarios plus randomized key bouncing,
// checked every cycle against a run-length debounce model.
module tb_key_pulse_gen;

    localparam int NK  = 3;
    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 4;

    logic          clk = 1'b0;
    logic          i_rst_n;
    logic [NK-1:0] i_key;
    logic [NK-1:0] o_pulse;
    logic [NK-1:0] o_level;

    int checks = 0;
    int errors = 0;

    key_pulse_gen #(
        .NUM_KEYS   (NK),
        .DEB_CYCLES (DEB),
        .REP_DELAY  (RD),
        .REP_PERIOD (RP)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (i_rst_n),
        .i_key   (i_key),
        .o_pulse (o_pulse),
        .o_level (o_level)
    );

    always #5 clk = ~clk;

    // Model: raw key seen two edges late; level flips once DEB consecutive
    // samples disagree with it; a pulse marks each flip to pressed.
    logic [NK-1:0] m0 = '1;
    logic [NK-1:0] m1 = '1;
    logic [NK-1:0] mlev = '0;
    logic [NK-1:0] mpul = '0;
    logic [NK-1:0] p_s;
    int            run [NK];
    int            held [NK];
    int            pcnt [NK];

    initial begin
        for (int k = 0; k < NK; k++) begin
            run[k]  = 0;
            held[k] = 0;
            pcnt[k] = 0;
        end
    end

    task automatic lit(input string nm, input logic [NK-1:0] act, input logic [NK-1:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp_v, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!i_rst_n) begin
            m0   = '1;
            m1   = '1;
            mlev = '0;
            mpul = '0;
            for (int k = 0; k < NK; k++) begin
                run[k]  = 0;
                held[k] = 0;
            end
        end else begin
            mpul = '0;
            p_s  = ~m1;
            for (int k = 0; k < NK; k++) begin
`ifdef KEY_PULSE_AUTOREPEAT_EN
                if (mlev[k] && p_s[k] && run[k] == 0) begin
                    held[k]++;
                    if (held[k] == RD || (held[k] > RD && (held[k] - RD) % RP == 0))
                        mpul[k] = 1'b1;
                end
`endif
                if (p_s[k] != mlev[k]) begin
                    run[k]++;
                    if (run[k] == DEB) begin
                        mlev[k] = p_s[k];
                        mpul[k] = p_s[k];
                        run[k]  = 0;
                        held[k] = 0;
                    end
                end else begin
                    run[k] = 0;
                end
            end
            m1 = m0;
            m0 = i_key;
        end
        #1;
        lit("model_pulse", o_pulse, mpul);
        lit("model_level", o_level, mlev);
        for (int k = 0; k < NK; k++) pcnt[k] += int'(o_pulse[k]);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic hold_key(input logic [NK-1:0] v, input int n);
        @(negedge clk);
        i_key = v;
        repeat (n - 1) @(negedge clk);
    endtask

    initial begin
        int            len;
        logic [NK-1:0] v;
        i_key   = '1;
        i_rst_n = 1'b0;
        repeat (3) @(negedge clk);
        lit("reset_pulse", o_pulse, 3'b000);
        lit("reset_level", o_level, 3'b000);
        i_rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Clean press on key 0: edge 0 is the next posedge.
        @(negedge clk);
        i_key = 3'b110;
        tick(5);
        lit("t1_before_accept", o_pulse, 3'b000);
        lit("t1_level_before", o_level, 3'b000);
        tick(1);
        lit("t1_pulse", o_pulse, 3'b001);
        lit("t1_level", o_level, 3'b001);
        tick(1);
        lit("t1_pulse_once", o_pulse, 3'b000);

        // Long hold, then release.
        pcnt[0] = 1;
        tick(200);
`ifndef KEY_PULSE_AUTOREPEAT_EN
        checks++;
        if (pcnt[0] != 1) begin
            errors++;
            $display("FAIL t3_hold_pulses: got %0d expected 1", pcnt[0]);
        end
`endif
        @(negedge clk);
        i_key = 3'b111;
        pcnt[0] = 0;
        tick(5);
        lit("t3_level_held", o_level, 3'b001);
        tick(1);
        lit("t3_level_released", o_level, 3'b000);
        checks++;
        if (pcnt[0] != 0) begin
            errors++;
            $display("FAIL t3_release_pulse: got %0d expected 0", pcnt[0]);
        end

        // Bounce on key 1.
        pcnt[1] = 0;
        hold_key(3'b101, 3);
        hold_key(3'b111, 1);
        hold_key(3'b101, 3);
        hold_key(3'b111, 10);
        lit("t2_level", o_level, 3'b000);
        checks++;
        if (pcnt[1] != 0) begin
            errors++;
            $display("FAIL t2_bounce_pulses: got %0d expected 0", pcnt[1]);
        end

        // Simultaneous press.
        @(negedge clk);
        i_key = 3'b000;
        tick(5);
        lit("t4_before", o_pulse, 3'b000);
        tick(1);
        lit("t4_pulse", o_pulse, 3'b111);
        tick(1);
        lit("t4_once", o_pulse, 3'b000);
        lit("t4_level", o_level, 3'b111);
        hold_key(3'b111, 12);

        // Reset in the middle of key 2's debounce while key 0 is held.
        hold_key(3'b110, 10);
        i_key = 3'b010;
        repeat (3) @(posedge clk);
        @(negedge clk);
        i_rst_n = 1'b0;
        #1;
        lit("t5_rst_level", o_level, 3'b000);
        lit("t5_rst_pulse", o_pulse, 3'b000);
        repeat (2) @(negedge clk);
        i_rst_n = 1'b1;
        tick(5);
        lit("t5_before", o_pulse, 3'b000);
        tick(1);
        lit("t5_pulse", o_pulse, 3'b101);
        lit("t5_level", o_level, 3'b101);
        hold_key(3'b111, 12);

        // Randomized bouncing with occasional resets.
        for (int s = 0; s < 400; s++) begin
            v = NK'($urandom);
            if ($urandom_range(0, 3) == 0) len = $urandom_range(1, 3);
            else len = $urandom_range(4, 40);
            if ($urandom_range(0, 39) == 0) begin
                @(negedge clk);
                i_rst_n = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                i_rst_n = 1'b1;
            end
            hold_key(v, len);
        end
        hold_key(3'b111, 12);
        tick(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
